ks_control_unit_mc: RTL

KS_CONTROL_UNIT_MC -- requirements
Module: ks_control_unit_mc

---
 rtl/k_and_s_pkg.sv | 23 ++
 rtl/ks_control_unit_mc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/k_and_s_pkg.sv
// Shared opcode encoding for the K&S decoder and control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

endpackage

// File: rtl/ks_control_unit_mc.sv
// Multi-cycle K&S control FSM with parameterized RAM wait states and retired-instruction count.
// Optional feature: define KS_CU_RESUME_EN to let resume leave HALTED.
//
// state      | meaning
// FETCH      | present PC to RAM
// FETCH_WAIT | wait for instruction word, latch IR and bump PC on exit
// DECODE     | branch resolution, pick ALU op or memory path
// EXEC_ALU   | write ALU result (and flags unless MOVE)
// LOAD_WAIT  | wait for RAM read data
// LOAD_WB    | write RAM data into register file
// STORE_WAIT | wait for RAM, single write strobe on exit
// HALTED     | stopped
module ks_control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int ICNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    mem_ready,
  input  logic                    resume,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [1:0]              operation,
  output logic                    busy,
  output logic [ICNT_W-1:0]       instr_count
);

  typedef enum logic [2:0] {
    FETCH, FETCH_WAIT, DECODE, EXEC_ALU, LOAD_WAIT, LOAD_WB, STORE_WAIT, HALTED
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, state_nx;
  logic [3:0] wait_cnt, wait_cnt_nx;
  logic [1:0] op_q;
  logic       flags_upd_q;
  logic [1:0] dec_op;
  logic       dec_alu, dec_move, take_branch;
  logic       wait_done, in_wait, retire;
  logic       unused_inputs;

`ifdef KS_CU_RESUME_EN
  assign unused_inputs = signed_overflow;
`else
  assign unused_inputs = signed_overflow ^ resume;
`endif

  assign wait_done = (wait_cnt >= WAIT_LAST) && mem_ready;
  assign in_wait   = (state == FETCH_WAIT) || (state == LOAD_WAIT) || (state == STORE_WAIT);

  always_comb begin
    dec_op   = 2'b00;
    dec_alu  = 1'b0;
    dec_move = 1'b0;
    case (decoded_instruction)
      I_ADD:   begin dec_op = 2'b00; dec_alu = 1'b1; end
      I_AND:   begin dec_op = 2'b01; dec_alu = 1'b1; end
      I_OR:    begin dec_op = 2'b10; dec_alu = 1'b1; end
      I_MOVE:  begin dec_op = 2'b10; dec_alu = 1'b1; dec_move = 1'b1; end
      I_SUB:   begin dec_op = 2'b11; dec_alu = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    take_branch = 1'b0;
    case (decoded_instruction)
      I_BRANCH: take_branch = 1'b1;
      I_BZERO:  take_branch = zero_op;
      I_BNZERO: take_branch = !zero_op;
      I_BNEG:   take_branch = neg_op;
      I_BNNEG:  take_branch = !neg_op;
      I_BOV:    take_branch = unsigned_overflow;
      I_BNOV:   take_branch = !unsigned_overflow;
      default:  take_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_nx         = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    operation        = 2'b00;
    busy             = 1'b0;
    case (state)
      FETCH: state_nx = FETCH_WAIT;
      FETCH_WAIT: begin
        busy = 1'b1;
        if (wait_done) begin
          ir_enable = 1'b1;
          pc_enable = 1'b1;
          state_nx  = DECODE;
        end
      end
      DECODE: begin
        state_nx = FETCH;
        if (dec_alu) begin
          operation = dec_op;
          state_nx  = EXEC_ALU;
        end else begin
          case (decoded_instruction)
            I_LOAD:  begin addr_sel = 1'b1; state_nx = LOAD_WAIT; end
            I_STORE: begin addr_sel = 1'b1; state_nx = STORE_WAIT; end
            I_HALT:  state_nx = HALTED;
            default: begin
              branch    = take_branch;
              pc_enable = take_branch;
            end
          endcase
        end
      end
      EXEC_ALU: begin
        write_reg_enable = 1'b1;
        operation        = op_q;
        flags_reg_enable = flags_upd_q;
        state_nx         = FETCH;
      end
      LOAD_WAIT: begin
        busy     = 1'b1;
        addr_sel = 1'b1;
        c_sel    = 1'b1;
        if (wait_done) state_nx = LOAD_WB;
      end
      LOAD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        state_nx         = FETCH;
      end
      STORE_WAIT: begin
        busy     = 1'b1;
        addr_sel = 1'b1;
        if (wait_done) begin
          ram_write_enable = 1'b1;
          state_nx         = FETCH;
        end
      end
      HALTED: begin
        halt = 1'b1;
`ifdef KS_CU_RESUME_EN
        if (resume) state_nx = FETCH;
`else
        state_nx = HALTED;
`endif
      end
      default: state_nx = FETCH;
    endcase
  end

  // Resuming from HALTED is not a retirement; HALT itself retires on entry.
  always_comb begin
    retire = ((state_nx == FETCH) &&
              ((state == DECODE) || (state == EXEC_ALU) ||
               (state == LOAD_WB) || (state == STORE_WAIT))) ||
             ((state_nx == HALTED) && (state != HALTED));
    wait_cnt_nx = 4'd0;
    if (in_wait && (state_nx == state))
      wait_cnt_nx = (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      wait_cnt    <= 4'd0;
      instr_count <= '0;
      op_q        <= 2'b00;
      flags_upd_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (retire) instr_count <= instr_count + ICNT_W'(1);
      if (state == DECODE) begin
        op_q        <= dec_op;
        flags_upd_q <= dec_alu && !dec_move;
      end
    end
  end

endmodule
